freq_meter_bcd: RTL and testbench
=================================

// Module: freq_meter_bcd
// PURPOSE
//  Fully synchronous, parametrised BCD frequency meter: next generation of the 8-digit 1 s gate counter.
//  Samples asynchronous FIN in the CLK domain and counts its rising edges over a programmable gate window.
//  Latches the decimal result into an output register with a valid strobe and an overflow flag.
//  Sits between a raw input pin and the display/readout logic.
// PARAMETERS
//  DIGITS       8           number of BCD digits (1..16); result width 4*DIGITS
//  GATE_CYCLES  50_000_000  CLK cycles per gate window (>=2); 1 s at 50 MHz
// PORTS
//  CLK     in   1          system clock, all logic on rising edge
//  RST     in   1          synchronous, active-high reset
//  EN      in   1          continuous-measurement enable
//  FIN     in   1          asynchronous input signal to be measured
//  DATOUT  out  4*DIGITS   latched BCD result, digit 0 in [3:0]
//  VALID   out  1          one-cycle pulse: DATOUT/OVF updated this cycle
//  OVF     out  1          last window exceeded 10^DIGITS-1 edges
//  BUSY    out  1          high while a window is in progress (CLEAR/GATE/LOAD)
// BEHAVIOUR
//  - Reset: DATOUT=0, VALID=0, OVF=0, BUSY=0, state IDLE, counters and sync flops cleared.
//  - FIN path: 2-flop synchroniser + edge register; edge = sync & ~prev; 3-cycle latency pin->edge.
//  - FSM: IDLE -> (EN) CLEAR -> GATE -> LOAD -> (EN ? CLEAR : IDLE).
//    CLEAR 1 cycle: zero digit counters, overflow sticky, gate timer.
//    GATE exactly GATE_CYCLES cycles; edge counted in any GATE cycle incl. first and last.
//    LOAD 1 cycle: DATOUT<=counters, OVF<=sticky; VALID=1 in the cycle after LOAD.
//  - Edges detected in IDLE/CLEAR/LOAD are discarded (dead time 2 cycles per window).
//  - Counting: ripple-free synchronous BCD chain; digit i increments when all lower digits are 9
//    and edge=1; 9 wraps to 0. Carry out of top digit sets overflow sticky.
//  - Max measurable FIN < CLK/2; faster inputs alias (not flagged).
//  - EN deasserted mid-window: current window completes and loads, then IDLE.
//  - EN re-asserted in LOAD cycle: next window starts (CLEAR) without passing IDLE.
//  - RST mid-window: immediate return to reset state; partial count discarded, DATOUT cleared.
//  - DATOUT/OVF hold between VALID pulses.
// CONFIGURATION
//  FREQ_SAT_EN defined: on overflow DATOUT loads all digits = 9 (saturated), OVF=1.
//  FREQ_SAT_EN undefined: DATOUT loads wrapped count (edges mod 10^DIGITS), OVF=1.
// STRUCTURE
//  Package freq_meter_pkg: FSM state encoding (IDLE/CLEAR/GATE/LOAD), BCD_MAX=4'd9, gate timer width fn.
//  Sub-module bcd_digit_cnt: one 4-bit BCD digit, inputs CLK/RST/CLR/INC, outputs Q/AT9;
//  generated DIGITS times; carry chain by AND of AT9 terms in parent.
// TESTING (sim: DIGITS=4, GATE_CYCLES=100 unless stated)
//  1 FIN period 10 CLK, EN=1 -> first VALID: DATOUT=16'h0010, OVF=0; repeats every 102 cycles.
//  2 FIN static 0 then static 1 -> DATOUT=16'h0000 each window, OVF=0.
//  3 DIGITS=2, GATE_CYCLES=1000, FIN period 2 -> OVF=1; SAT_EN: DATOUT=8'h99; else 8'h00 (500 mod 100).
//  4 FIN period 4, count crossing 9->10 and 99->100 (GATE_CYCLES=400) -> DATOUT=16'h0100 exact.
//  5 RST pulse at GATE cycle 50 -> DATOUT=0, VALID not pulsed, BUSY=0 next cycle; restarts cleanly.
//  6 EN low at GATE cycle 30 -> one VALID with full-window count, then BUSY=0, no further VALID.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the BCD frequency meter: FSM encoding, BCD limit, timer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Gate timer runs 0 .. cycles-1, so it needs clog2(cycles) bits (minimum 1).
  function automatic int gate_timer_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One synchronous BCD digit (0..9) with clear and increment; AT9 feeds the parent's carry chain.
// Latency: Q updates on the clock edge after INC/CLR.
// Backpressure: none; an INC is always accepted.
// Ports: CLK clock, RST sync active-high reset, CLR sync clear, INC count enable,
//        Q current digit, AT9 high when the digit holds 9.
module bcd_digit_cnt
  import freq_meter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       INC,
  output logic [3:0] Q,
  output logic       AT9
);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Q <= 4'd0;
    end else if (INC) begin
      Q <= (Q == BCD_MAX) ? 4'd0 : Q + 4'd1;
    end
  end

  assign AT9 = (Q == BCD_MAX);

endmodule

// File: rtl/freq_meter_bcd.sv
// BCD frequency meter: counts synchronised FIN rising edges over a GATE_CYCLES window, latches result.
// Latency: 3 cycles pin->edge; result VALID one cycle after LOAD; window period GATE_CYCLES+2.
// Backpressure: none; VALID is a one-cycle strobe, DATOUT/OVF hold until the next strobe.
// Ports: CLK clock, RST sync active-high reset, EN continuous-measurement enable, FIN async input,
//        DATOUT BCD result (digit 0 in [3:0]), VALID result strobe, OVF window overflow, BUSY window active.
// Option: define FREQ_SAT_EN to load all-9s on overflow instead of the wrapped count.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int GATE_CYCLES = 50_000_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                FIN,
  output logic [4*DIGITS-1:0] DATOUT,
  output logic                VALID,
  output logic                OVF,
  output logic                BUSY
);

  localparam int TW = gate_timer_width(GATE_CYCLES);

  logic                fin_s1;
  logic                fin_s2;
  logic                fin_prev;
  logic                fin_edge;
  state_t              state;
  logic [TW-1:0]       gate_tmr;
  logic                ovf_sticky;
  logic                cnt_clr;
  logic [DIGITS-1:0]   at9;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] cnt_q;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fin_s1   <= 1'b0;
      fin_s2   <= 1'b0;
      fin_prev <= 1'b0;
    end else begin
      fin_s1   <= FIN;
      fin_s2   <= fin_s1;
      fin_prev <= fin_s2;
    end
  end

  assign fin_edge = fin_s2 & ~fin_prev;

  // Edges outside GATE are dropped here, giving the 2-cycle dead time per window.
  assign cnt_clr  = (state == ST_CLEAR);
  assign carry[0] = (state == ST_GATE) & fin_edge;

  // Digit i steps only when every lower digit sits at 9; carry[DIGITS] is the overflow.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .CLK (CLK),
      .RST (RST),
      .CLR (cnt_clr),
      .INC (carry[i]),
      .Q   (cnt_q[4*i +: 4]),
      .AT9 (at9[i])
    );
    assign carry[i+1] = carry[i] & at9[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      gate_tmr   <= '0;
      ovf_sticky <= 1'b0;
      DATOUT     <= '0;
      VALID      <= 1'b0;
      OVF        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (carry[DIGITS]) begin
        ovf_sticky <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (EN) begin
            state <= ST_CLEAR;
            BUSY  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          gate_tmr   <= '0;
          ovf_sticky <= 1'b0;
          state      <= ST_GATE;
        end
        ST_GATE: begin
          if (gate_tmr == TW'(GATE_CYCLES - 1)) begin
            state <= ST_LOAD;
          end else begin
            gate_tmr <= gate_tmr + TW'(1);
          end
        end
        ST_LOAD: begin
          VALID <= 1'b1;
          OVF   <= ovf_sticky;
`ifdef FREQ_SAT_EN
          DATOUT <= ovf_sticky ? {DIGITS{BCD_MAX}} : cnt_q;
`else
          DATOUT <= cnt_q;
`endif
          // EN seen here chains straight into the next window.
          if (EN) begin
            state <= ST_CLEAR;
          end else begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
module tb_freq_meter_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic fin_a = 1'b0, fin_b = 1'b0, fin_c = 1'b0;

  logic [15:0] dat_a, dat_c;
  logic [7:0]  dat_b;
  logic valid_a, valid_b, valid_c;
  logic ovf_a, ovf_b, ovf_c;
  logic busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  freq_meter_bcd #(.DIGITS(4), .GATE_CYCLES(100)) dut_a (
    .CLK(clk), .RST(rst), .EN(en_a), .FIN(fin_a),
    .DATOUT(dat_a), .VALID(valid_a), .OVF(ovf_a), .BUSY(busy_a));

  freq_meter_bcd #(.DIGITS(2), .GATE_CYCLES(1000)) dut_b (
    .CLK(clk), .RST(rst), .EN(en_b), .FIN(fin_b),
    .DATOUT(dat_b), .VALID(valid_b), .OVF(ovf_b), .BUSY(busy_b));

  freq_meter_bcd #(.DIGITS(4), .GATE_CYCLES(400)) dut_c (
    .CLK(clk), .RST(rst), .EN(en_c), .FIN(fin_c),
    .DATOUT(dat_c), .VALID(valid_c), .OVF(ovf_c), .BUSY(busy_c));

  // FIN generators: period 0 means static level, otherwise a square wave of that period in CLK cycles.
  int per_a = 0, per_b = 0, per_c = 0;
  logic lvl_a = 1'b0, lvl_b = 1'b0, lvl_c = 1'b0;
  int hc_a = 0, hc_b = 0, hc_c = 0;

  always @(negedge clk) begin
    if (per_a == 0) fin_a = lvl_a;
    else begin hc_a++; if (hc_a >= per_a / 2) begin fin_a = ~fin_a; hc_a = 0; end end
    if (per_b == 0) fin_b = lvl_b;
    else begin hc_b++; if (hc_b >= per_b / 2) begin fin_b = ~fin_b; hc_b = 0; end end
    if (per_c == 0) fin_c = lvl_c;
    else begin hc_c++; if (hc_c >= per_c / 2) begin fin_c = ~fin_c; hc_c = 0; end end
  end

  // Scoreboards: {ovf, datout}
  logic [16:0] q_a[$];
  logic [8:0]  q_b[$];
  logic [16:0] q_c[$];
  bit per_chk_a = 1'b0;
  int last_a = -1;

  always @(negedge clk) begin
    logic [16:0] e;
    if (valid_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_valid: got datout=%h ovf=%b, required no VALID", dat_a, ovf_a);
      end else begin
        e = q_a.pop_front();
        if ({ovf_a, dat_a} !== e)
          begin errors++; $display("FAIL a_result: got ovf=%b datout=%h, required ovf=%b datout=%h", ovf_a, dat_a, e[16], e[15:0]); end
      end
      if (per_chk_a && last_a >= 0) begin
        checks++;
        if (cyc - last_a != 102)
          begin errors++; $display("FAIL a_valid_period: got %0d cycles, required 102", cyc - last_a); end
      end
      last_a = cyc;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (valid_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_valid: got datout=%h ovf=%b, required no VALID", dat_b, ovf_b);
      end else begin
        e = q_b.pop_front();
        if ({ovf_b, dat_b} !== e)
          begin errors++; $display("FAIL b_result: got ovf=%b datout=%h, required ovf=%b datout=%h", ovf_b, dat_b, e[8], e[7:0]); end
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (valid_c) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected_valid: got datout=%h ovf=%b, required no VALID", dat_c, ovf_c);
      end else begin
        e = q_c.pop_front();
        if ({ovf_c, dat_c} !== e)
          begin errors++; $display("FAIL c_result: got ovf=%b datout=%h, required ovf=%b datout=%h", ovf_c, dat_c, e[16], e[15:0]); end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int which, input int limit);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      got = (which == 0) ? valid_a : (which == 1) ? valid_b : valid_c;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_valid_%0d: no VALID within %0d cycles, required one", which, limit);
    end
  endtask

  // One EN cycle starts exactly one window, which then runs to completion.
  task automatic run_one(input int which, input int limit);
    if (which == 0) en_a = 1'b1; else if (which == 1) en_b = 1'b1; else en_c = 1'b1;
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    wait_valid(which, limit);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dat_a",   32'(dat_a),   32'h0);
    chk("rst_valid_a", 32'(valid_a), 32'h0);
    chk("rst_ovf_a",   32'(ovf_a),   32'h0);
    chk("rst_busy_a",  32'(busy_a),  32'h0);
    chk("rst_dat_b",   32'(dat_b),   32'h0);
    chk("rst_busy_c",  32'(busy_c),  32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous measurement, FIN period 10; EN dropped at GATE cycle 30 of the third window
    per_a = 10;
    repeat (5) @(negedge clk);
    last_a = -1;
    per_chk_a = 1'b1;
    repeat (3) q_a.push_back({1'b0, 16'h0010});
    en_a = 1'b1;
    wait_valid(0, 200);
    wait_valid(0, 200);
    repeat (31) @(negedge clk);
    chk("busy_in_gate_a", 32'(busy_a), 32'h1);
    en_a = 1'b0;
    wait_valid(0, 200);
    @(negedge clk);
    chk("busy_after_stop_a", 32'(busy_a), 32'h0);
    repeat (300) @(negedge clk);
    chk("hold_dat_a", 32'(dat_a), 32'h0010);
    per_chk_a = 1'b0;

    // Static FIN low, then static high
    per_a = 0; lvl_a = 1'b0;
    repeat (5) @(negedge clk);
    q_a.push_back({1'b0, 16'h0000});
    run_one(0, 200);
    repeat (3) @(negedge clk);
    lvl_a = 1'b1;
    repeat (10) @(negedge clk);
    q_a.push_back({1'b0, 16'h0000});
    run_one(0, 200);
    repeat (3) @(negedge clk);

    // Reset at GATE cycle 50 of a window with a non-zero result held
    per_a = 10; lvl_a = 1'b0;
    q_a.push_back({1'b0, 16'h0010});
    run_one(0, 200);
    repeat (3) @(negedge clk);
    en_a = 1'b1;
    repeat (52) @(negedge clk);
    chk("busy_pre_rst_a", 32'(busy_a), 32'h1);
    rst = 1'b1; en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy_a", 32'(busy_a), 32'h0);
    chk("mid_rst_dat_a",  32'(dat_a),  32'h0);
    chk("mid_rst_valid_a", 32'(valid_a), 32'h0);
    repeat (200) @(negedge clk);
    q_a.push_back({1'b0, 16'h0010});
    run_one(0, 200);

    // BCD carries 9->10 and 99->100: period 4 over 400 cycles
    per_c = 4;
    repeat (5) @(negedge clk);
    q_c.push_back({1'b0, 16'h0100});
    run_one(2, 600);

    // Overflow: 500 edges into 2 digits, then a clean window clears OVF
    per_b = 2;
    repeat (5) @(negedge clk);
`ifdef FREQ_SAT_EN
    q_b.push_back({1'b1, 8'h99});
`else
    q_b.push_back({1'b1, 8'h00});
`endif
    run_one(1, 1200);
    per_b = 0; lvl_b = 1'b0;
    repeat (5) @(negedge clk);
    q_b.push_back({1'b0, 8'h00});
    run_one(1, 1200);
    @(negedge clk);
    chk("busy_end_b", 32'(busy_b), 32'h0);

    repeat (5) @(negedge clk);
    chk("q_a_drained", 32'(q_a.size()), 32'h0);
    chk("q_b_drained", 32'(q_b.size()), 32'h0);
    chk("q_c_drained", 32'(q_c.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
